seg_scan_decoder: RTL
=====================

# seg_scan_decoder

Recovers the displayed number from a multiplexed, active-low four-digit seven-segment bus (8-bit segments, 4-bit one-hot-low digit select), which is the receive end of the display scan interface. The block synchronises the bus, waits for each digit to settle and decodes each segment pattern to BCD. When enough consecutive scan frames agree, it reassembles a 12-bit binary value. It sits on the board-test/loopback path and in self-checking benches beside the number display driver.

## Interface
- SETTLE, default 4: clk cycles after a select change before the segment bus is sampled.
- STABLE_FRAMES, default 2: number of consecutive identical complete frames required before value is updated.
- TIMEOUT, default 1048575: clk cycles without a select change before stale asserts; counter width is clog2(TIMEOUT+1).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- seg_in  in  8  active-low segments; bit7=a, 6=b, 5=c, 4=d, 3=e, 2=f, 1=g, 0=dp.
- sel_in  in  4  active-low one-hot select; 0111=thousands, 1011=hundreds, 1101=tens, 1110=ones.
- value  out  12  binary value, hundreds*100+tens*10+ones; reset 0.
- digits  out  12  last accepted BCD {hundreds,tens,ones}; reset 0.
- value_valid  out  1  one-cycle pulse when value/digits update; reset 0.
- seg_err  out  1  last frame contained an illegal pattern, a non-BCD digit or a non-zero thousands digit; reset 0.
- stale  out  1  no scan activity within TIMEOUT; reset 1.

## Operation
- seg_in and sel_in pass through 2-flop synchronisers. All logic below uses the synchronised copies (seg_s, sel_s) and sel_q, which is sel_s delayed one cycle.
- Per-digit FSM:
  - WAIT_EDGE: sel_s != sel_q loads the settle counter and moves to SETTLING.
  - SETTLING: the counter counts SETTLE cycles. Another select change restarts the count. At expiry the FSM samples seg_s and returns to WAIT_EDGE.
- Illegal select (not exactly one zero, e.g. 0000 or 1111) at sample time aborts the frame. The mask clears and nothing is stored.
- Pattern decode uses the 16 hex glyph constants; dp is ignored. Glyphs in active-low a..g order: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; A-F per package.
  - An unmatched pattern marks the frame bad.
  - A-F marks the frame bad, because the display source is BCD.
  - A thousands digit other than 0 marks the frame bad.
- Frame assembly:
  - A 4-bit capture mask records the positions sampled. The digit is stored into its slot.
  - Sampling a position already in the mask before the mask is full restarts the frame with only that position set.
  - When the mask reaches 1111, the frame is complete and the mask clears.
- Complete good frame:
  - Compare {h,t,o} with the previous good frame. Equal increments the match count, saturating at STABLE_FRAMES. Different sets the match count to 1.
  - When the count first reaches STABLE_FRAMES, or is already saturated and the frame equals the held value, load digits and value, pulse value_valid, and clear seg_err.
  - Value is computed as h*100+t*10+o using shift-add; the maximum is 999.
- Complete bad frame: set seg_err, reset the match count to 0, and hold value/digits.
- Every select change reloads the timeout counter and clears stale. When the counter expires, stale is set; value/digits are held.

## Timing
- Input to sel_s: 2 cycles. Edge detect: +1 cycle. Sample: SETTLE cycles after detection.
- value/digits/value_valid register on the cycle after the sample that completes the qualifying frame.
- value_valid pulses once per qualifying frame (re-pulses each agreeing frame while saturated).
- Simultaneous select change and settle expiry: the sample is discarded and the count restarts.
- rst mid-frame: all state and outputs return to reset values immediately. Capture resumes at the first select edge after release.

## Structure
- Package seg_scan_pkg: the 16 active-low glyph constants, the four select codes, and digit slot indices.
- Sub-module seg_glyph_decode: combinational 7-bit pattern to {hit, digit[3:0]}. Everything else is in the top module.

## Test plan
- Steady scan of 0, 4, 2, 7 (thousands..ones), SETTLE=4, STABLE_FRAMES=2 -> after 2 frames value=427 and digits=0x427, value_valid pulses once per frame thereafter, seg_err=0.
- Input changes from 427 to 999 mid-stream -> value holds 427 for one 999 frame, then becomes 999 (0x3E7).
- Ones digit glyph 0111111 (illegal) for one frame -> seg_err=1 and value holds. The next two good frames clear seg_err and pulse valid.
- sel_in=0000 injected mid-frame -> frame aborts and no update. A duplicate tens select restarts the mask.
- Glitch on seg_in lasting less than SETTLE cycles right after the select edge -> no error and the correct digit is sampled.
- Scan stopped for TIMEOUT+1 cycles -> stale=1 and value held. rst asserted mid-frame -> value=0, stale=1, value_valid=0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: glyph table, select codes, slot indices and helpers shared by the scan decoder
package seg_scan_pkg;
  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;
  localparam logic [15:0][6:0] GLYPHS = {GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
                                         GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0};
  localparam logic [3:0] SEL_THOU = 4'b0111;
  localparam logic [3:0] SEL_HUND = 4'b1011;
  localparam logic [3:0] SEL_TENS = 4'b1101;
  localparam logic [3:0] SEL_ONES = 4'b1110;
  localparam logic [1:0] SLOT_THOU = 2'd3;
  localparam logic [1:0] SLOT_HUND = 2'd2;
  localparam logic [1:0] SLOT_TENS = 2'd1;
  localparam logic [1:0] SLOT_ONES = 2'd0;
  typedef enum logic {WAIT_EDGE, SETTLING} scan_state_t;
  function automatic logic [1:0] sel_slot(input logic [3:0] sel);
    return sel == SEL_THOU ? SLOT_THOU : sel == SEL_HUND ? SLOT_HUND : sel == SEL_TENS ? SLOT_TENS : SLOT_ONES;
  endfunction
  function automatic logic [11:0] bcd_to_bin(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    logic [11:0] hw, tw;
    hw = {8'd0, h};
    tw = {8'd0, t};
    return (hw << 6) + (hw << 5) + (hw << 2) + (tw << 3) + (tw << 1) + {8'd0, o};
  endfunction
endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: multiplexed seven-segment scan bus and the recovered-number outputs
interface seg_scan_if;
  logic [7:0] seg_in;
  logic [3:0] sel_in;
  logic [11:0] value;
  logic [11:0] digits;
  logic value_valid;
  logic seg_err;
  logic stale;
  modport master (output seg_in, sel_in, input value, digits, value_valid, seg_err, stale);
  modport slave (input seg_in, sel_in, output value, digits, value_valid, seg_err, stale);
endinterface

// File: rtl/seg_glyph_decode.sv
// seg_glyph_decode: maps an active-low a..g segment pattern to its hex digit
module seg_glyph_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] pat,
  output logic       hit,
  output logic [3:0] digit
);
  // search the sixteen distinct glyphs; at most one can match
  always_comb begin
    hit = 1'b0;
    digit = 4'd0;
    for (int i = 0; i < 16; i++)
      if (pat == GLYPHS[i]) begin
        hit = 1'b1;
        digit = 4'(i);
      end
  end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers a 0..999 value from an active-low multiplexed seven-segment scan bus
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int SETTLE = 4,
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT = 1048575
) (
  input logic clk,
  input logic rst,
  seg_scan_if.slave bus
);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int MW = $clog2(STABLE_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [MW-1:0] STABLE_N = MW'(STABLE_FRAMES);
  localparam logic [TW-1:0] TIMEOUT_N = TW'(TIMEOUT);
  logic [6:0] seg_m, seg_s;
  logic [3:0] sel_m, sel_s, sel_q;
  scan_state_t state, state_nx;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] to_cnt;
  logic [MW-1:0] match_cnt, match_nx;
  logic [3:0] mask, slot_bit;
  logic [3:0] d_h, d_t, d_o, cur_h, cur_t, cur_o, digit;
  logic [11:0] prev, value_r, digits_r;
  logic frame_bad, valid_r, err_r, stale_r;
  logic sel_chg, sample, sel_ok, hit, digit_bad, restart, complete, good, same, fire;
  seg_glyph_decode u_dec (.pat(seg_s), .hit(hit), .digit(digit));
  assign sel_chg = sel_s != sel_q;
  assign bus.value = value_r;
  assign bus.digits = digits_r;
  assign bus.value_valid = valid_r;
  assign bus.seg_err = err_r;
  assign bus.stale = stale_r;
  // two-flop synchronisers plus a delayed select copy for edge detection; dp is never decoded
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seg_m <= '1;
      seg_s <= '1;
      sel_m <= '1;
      sel_s <= '1;
      sel_q <= '1;
    end else begin
      seg_m <= bus.seg_in[7:1];
      seg_s <= seg_m;
      sel_m <= bus.sel_in;
      sel_s <= sel_m;
      sel_q <= sel_s;
    end
  // scan state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= WAIT_EDGE;
    else state <= state_nx;
  // any select change (re)starts settling; expiry returns to waiting for the next edge
  always_comb state_nx = sel_chg ? SETTLING : (state == SETTLING && settle_cnt == '0) ? WAIT_EDGE : state;
  // sample strobe: settle expiry that does not coincide with a fresh select change
  always_comb sample = state == SETTLING && settle_cnt == '0 && !sel_chg;
  // settle counter, reloaded on every select change so late edges restart the wait
  always_ff @(posedge clk or posedge rst)
    if (rst) settle_cnt <= '0;
    else settle_cnt <= sel_chg ? SETTLE_LOAD : (state == SETTLING && settle_cnt != '0) ? settle_cnt - 1'b1 : settle_cnt;
  // classify the current sample and form the candidate frame with it substituted into its slot
  always_comb begin
    sel_ok = sel_s inside {SEL_THOU, SEL_HUND, SEL_TENS, SEL_ONES};
    slot_bit = 4'b0001 << sel_slot(sel_s);
    digit_bad = !hit || digit > 4'd9 || (sel_s == SEL_THOU && digit != 4'd0);
    restart = sel_ok && (mask & slot_bit) != '0;
    complete = sel_ok && !restart && (mask | slot_bit) == 4'b1111;
    good = !frame_bad && !digit_bad;
    cur_h = sel_s == SEL_HUND ? digit : d_h;
    cur_t = sel_s == SEL_TENS ? digit : d_t;
    cur_o = sel_s == SEL_ONES ? digit : d_o;
    same = {cur_h, cur_t, cur_o} == prev;
    match_nx = !same ? MW'(1) : match_cnt == STABLE_N ? match_cnt : match_cnt + 1'b1;
    fire = sample && complete && good && match_nx == STABLE_N
           && (!same || match_cnt != STABLE_N || {cur_h, cur_t, cur_o} == digits_r);
  end
  // capture mask, digit slots, frame-bad flag and agreement history, advanced on each sample
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mask <= '0;
      frame_bad <= 1'b0;
      d_h <= '0;
      d_t <= '0;
      d_o <= '0;
      prev <= '0;
      match_cnt <= '0;
    end else if (sample) begin
      if (!sel_ok) begin
        mask <= '0;
        frame_bad <= 1'b0;
      end else begin
        mask <= restart ? slot_bit : complete ? 4'b0000 : mask | slot_bit;
        frame_bad <= !complete && ((frame_bad && !restart) || digit_bad);
        d_h <= cur_h;
        d_t <= cur_t;
        d_o <= cur_o;
        if (complete) begin
          match_cnt <= good ? match_nx : '0;
          if (good) prev <= {cur_h, cur_t, cur_o};
        end
      end
    end
  // published result: loads on qualifying frames; a bad complete frame raises seg_err and holds
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      value_r <= '0;
      digits_r <= '0;
      valid_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      valid_r <= fire;
      if (fire) begin
        digits_r <= {cur_h, cur_t, cur_o};
        value_r <= bcd_to_bin(cur_h, cur_t, cur_o);
        err_r <= 1'b0;
      end else if (sample && complete && !good) err_r <= 1'b1;
    end
  // activity watchdog: select edges clear stale, a long quiet period sets it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      to_cnt <= '0;
      stale_r <= 1'b1;
    end else if (sel_chg) begin
      to_cnt <= '0;
      stale_r <= 1'b0;
    end else if (to_cnt == TIMEOUT_N) stale_r <= 1'b1;
    else to_cnt <= to_cnt + 1'b1;
endmodule
